// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS datapath: PC, IR, Data, A/B, ALUOut, 32x32 register file and ALU.
// Sequencing is owned entirely by the external controller; this block only registers and muxes.
module mips_multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcen,
  input  logic        irwrite,
  input  logic        regwrite,
  input  logic        alusrca,
  input  logic        iord,
  input  logic        memtoreg,
  input  logic        regdst,
  input  logic [1:0]  alusrcb,
  input  logic [1:0]  pcsrc,
  input  logic [2:0]  alucontrol,
  input  logic [31:0] readdata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero,
  output logic [31:0] adr,
  output logic [31:0] writedata
);

  logic [31:0] pc, instr, data, a, b, aluout;
  logic [31:0] rf [32];

  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic [31:0] signimm, srca, srcb, aluresult, pcnext;

  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign writedata = b;
  assign adr       = iord ? aluout : pc;

  assign ra1     = instr[25:21];
  assign ra2     = instr[20:16];
  assign wa      = regdst ? instr[15:11] : instr[20:16];
  assign wd      = memtoreg ? data : aluout;
  assign signimm = {{16{instr[15]}}, instr[15:0]};

  // Register 0 is forced to read zero even though its storage is never written.
  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];

  assign srca = alusrca ? a : pc;

  always_comb begin
    srcb = b;
    case (alusrcb)
      2'b00:   srcb = b;
      2'b01:   srcb = 32'd4;
      2'b10:   srcb = signimm;
      default: srcb = {signimm[29:0], 2'b00};
    endcase
  end

  always_comb begin
    aluresult = '0;
    case (alucontrol)
      3'b010:  aluresult = srca + srcb;
      3'b110:  aluresult = srca - srcb;
      3'b000:  aluresult = srca & srcb;
      3'b001:  aluresult = srca | srcb;
      3'b100:  aluresult = srca & ~srcb;
      3'b101:  aluresult = srca | ~srcb;
      3'b111:  aluresult = {31'b0, $signed(srca) < $signed(srcb)};
      default: aluresult = '0;
    endcase
  end

  assign zero = (aluresult == '0);

  always_comb begin
    pcnext = aluresult;
    case (pcsrc)
      2'b01:   pcnext = aluout;
      2'b10:   pcnext = {pc[31:28], instr[25:0], 2'b00};
      default: pcnext = aluresult;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      instr  <= '0;
      data   <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (pcen)    pc    <= pcnext;
      if (irwrite) instr <= readdata;
      data   <= readdata;
      a      <= rd1;
      b      <= rd2;
      aluout <= aluresult;
    end
  end

  // A/B sample rf before this edge's write lands, giving read-old-value on collision.
  always_ff @(posedge clk) begin
    if (reset)
      rf <= '{default: '0};
    else if (regwrite && (wa != '0))
      rf[wa] <= wd;
  end

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Scoreboard bench for mips_multicycle_datapath: expectations queued at stimulus, popped on observation.
module tb_mips_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v, got_v;
  logic [31:0] pc_m;

  mips_multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .readdata(readdata),
    .op(op), .funct(funct), .zero(zero), .adr(adr), .writedata(writedata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b100:  return x & ~y;
      3'b101:  return x | ~y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0;
    memtoreg = 0; regdst = 0; alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 3'b010;
    readdata = '0;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    pcen = 0; regwrite = 0; irwrite = 1; readdata = instr;
    tick();
    irwrite = 0;
  endtask

  task automatic fetch(input logic [31:0] instr);
    readdata = instr; irwrite = 1; pcen = 1; regwrite = 0;
    alusrca = 0; alusrcb = 2'b01; alucontrol = 3'b010; pcsrc = 2'b00; iord = 0;
    tick();
    irwrite = 0; pcen = 0;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [15:0] imm);
    load_ir({6'h08, 5'd0, r, imm});
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010;
    tick();
    tick();
    regdst = 0; memtoreg = 0; regwrite = 1;
    tick();
    regwrite = 0;
  endtask

  task automatic read_reg(input logic [4:0] r);
    load_ir({6'h00, 5'd0, r, 16'h0000});
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1; pcen = 1; irwrite = 1; regwrite = 1; readdata = 32'hFFFF_FFFF;
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    tick();
    idle();
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL reset_adr: got %h expected %h", got_v, exp_v); end
    got_v = {26'b0, op}; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL reset_op: got %h expected %h", got_v, exp_v); end
    got_v = {26'b0, funct}; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL reset_funct: got %h expected %h", got_v, exp_v); end
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL reset_writedata: got %h expected %h", got_v, exp_v); end
    for (int unsigned r = 1; r < 32; r += 10) begin
      sb.push_back(32'h0);
      read_reg(r[4:0]);
      got_v = writedata; exp_v = sb.pop_front(); vectors++;
      if (got_v !== exp_v) begin miscompares++; $display("FAIL reset_reg%0d: got %h expected %h", r, got_v, exp_v); end
    end
    pc_m = 32'h0;
  endtask

  task automatic test_fetch_addi();
    sb.push_back(pc_m + 32'd4); sb.push_back(32'h08); sb.push_back(32'h05);
    fetch(32'h2008_0005);
    pc_m = pc_m + 32'd4;
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL fetch_pc: got %h expected %h", got_v, exp_v); end
    got_v = {26'b0, op}; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL fetch_op: got %h expected %h", got_v, exp_v); end
    got_v = {26'b0, funct}; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL fetch_funct: got %h expected %h", got_v, exp_v); end
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010; iord = 1;
    sb.push_back(32'd5);
    tick();
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL addi_aluout: got %h expected %h", got_v, exp_v); end
    iord = 0; regdst = 0; memtoreg = 0; regwrite = 1;
    tick();
    regwrite = 0;
    sb.push_back(32'd5);
    tick();
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL addi_rf8: got %h expected %h", got_v, exp_v); end
  endtask

  task automatic run_beq(input logic [31:0] instr, input logic take, input logic exp_zero);
    fetch(instr);
    pc_m = pc_m + 32'd4;
    alusrca = 0; alusrcb = 2'b11; alucontrol = 3'b010; iord = 1;
    sb.push_back(pc_m + 32'd12);
    tick();
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL beq_target: got %h expected %h", got_v, exp_v); end
    iord = 0; alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b110; pcsrc = 2'b01; pcen = take;
    sb.push_back({31'b0, exp_zero});
    #1;
    got_v = {31'b0, zero}; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL beq_zero: got %h expected %h", got_v, exp_v); end
    if (take) pc_m = pc_m + 32'd12;
    sb.push_back(pc_m);
    tick();
    pcen = 0; pcsrc = 2'b00;
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL beq_pc: got %h expected %h", got_v, exp_v); end
  endtask

  task automatic test_branch();
    run_beq(32'h1108_0003, 1'b1, 1'b1);
    write_reg(5'd9, 16'd7);
    run_beq(32'h1109_0003, 1'b0, 1'b0);
  endtask

  task automatic test_alu_ops();
    load_ir(32'h0109_5820);
    tick();
    sb.push_back(32'h20);
    got_v = {26'b0, funct}; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL rtype_funct: got %h expected %h", got_v, exp_v); end
    alusrca = 1; alusrcb = 2'b00; iord = 1;
    for (int unsigned k = 0; k < 8; k++) begin
      alucontrol = k[2:0];
      sb.push_back({31'b0, alu_model(k[2:0], 32'd5, 32'd7) == 32'd0});
      sb.push_back(alu_model(k[2:0], 32'd5, 32'd7));
      #1;
      got_v = {31'b0, zero}; exp_v = sb.pop_front(); vectors++;
      if (got_v !== exp_v) begin miscompares++; $display("FAIL alu_zero_op%0d: got %h expected %h", k, got_v, exp_v); end
      tick();
      got_v = adr; exp_v = sb.pop_front(); vectors++;
      if (got_v !== exp_v) begin miscompares++; $display("FAIL alu_op%0d: got %h expected %h", k, got_v, exp_v); end
    end
    alucontrol = 3'b010; iord = 0;
    tick();
    regdst = 1; regwrite = 1;
    tick();
    regwrite = 0; regdst = 0;
    sb.push_back(32'd12);
    read_reg(5'd11);
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL regdst_rd11: got %h expected %h", got_v, exp_v); end
  endtask

  task automatic test_load_store();
    load_ir(32'h8C0A_0020);
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010; iord = 1;
    sb.push_back(32'h20);
    tick();
    tick();
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL lw_adr: got %h expected %h", got_v, exp_v); end
    readdata = 32'hDEAD_BEEF;
    tick();
    readdata = '0; memtoreg = 1; regdst = 0; regwrite = 1;
    tick();
    regwrite = 0; memtoreg = 0; iord = 0;
    sb.push_back(32'hDEAD_BEEF); sb.push_back(32'h2B);
    load_ir(32'hAC0A_0024);
    tick();
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL sw_writedata: got %h expected %h", got_v, exp_v); end
    got_v = {26'b0, op}; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL sw_op: got %h expected %h", got_v, exp_v); end
  endtask

  task automatic test_slt_jump();
    write_reg(5'd12, 16'hFFFF);
    write_reg(5'd13, 16'h0001);
    sb.push_back(32'hFFFF_FFFF);
    read_reg(5'd12);
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL signext_rf12: got %h expected %h", got_v, exp_v); end
    for (int unsigned s = 0; s < 2; s++) begin
      load_ir((s == 0) ? 32'h018D_002A : 32'h01AC_002A);
      tick();
      alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b111; iord = 1;
      sb.push_back((s == 0) ? 32'd0 : 32'd1);
      sb.push_back((s == 0) ? 32'd1 : 32'd0);
      #1;
      got_v = {31'b0, zero}; exp_v = sb.pop_front(); vectors++;
      if (got_v !== exp_v) begin miscompares++; $display("FAIL slt_zero_%0d: got %h expected %h", s, got_v, exp_v); end
      tick();
      got_v = adr; exp_v = sb.pop_front(); vectors++;
      if (got_v !== exp_v) begin miscompares++; $display("FAIL slt_result_%0d: got %h expected %h", s, got_v, exp_v); end
    end
    iord = 0; alucontrol = 3'b010;
    load_ir(32'h0800_0010);
    pcsrc = 2'b10; pcen = 1;
    pc_m = {pc_m[31:28], 26'h10, 2'b00};
    sb.push_back(pc_m);
    tick();
    pcen = 0; pcsrc = 2'b00;
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL jump_pc: got %h expected %h", got_v, exp_v); end
  endtask

  task automatic test_reg0_collision();
    iord = 1;
    sb.push_back(32'd7);
    write_reg(5'd0, 16'd7);
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL r0_aluout: got %h expected %h", got_v, exp_v); end
    iord = 0;
    sb.push_back(32'd0);
    read_reg(5'd0);
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL r0_reads_zero: got %h expected %h", got_v, exp_v); end
    load_ir({6'h08, 5'd9, 5'd9, 16'd100});
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010; iord = 1;
    tick();
    tick();
    regdst = 0; memtoreg = 0; regwrite = 1;
    sb.push_back(32'd7); sb.push_back(32'd107);
    tick();
    regwrite = 0;
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL collide_old_b: got %h expected %h", got_v, exp_v); end
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL collide_aluout: got %h expected %h", got_v, exp_v); end
    sb.push_back(32'd107);
    tick();
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL collide_new_b: got %h expected %h", got_v, exp_v); end
    sb.push_back(32'd207);
    tick();
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL collide_new_a: got %h expected %h", got_v, exp_v); end
    iord = 0;
  endtask

  task automatic test_reset_clears();
    idle();
    reset = 1; pcen = 1; irwrite = 1; regwrite = 1; readdata = 32'hFFFF_FFFF;
    sb.push_back(32'h0); sb.push_back(32'h0);
    tick();
    idle();
    got_v = adr; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL rereset_pc: got %h expected %h", got_v, exp_v); end
    got_v = {26'b0, op}; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL rereset_op: got %h expected %h", got_v, exp_v); end
    sb.push_back(32'h0);
    read_reg(5'd10);
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL rereset_rf10: got %h expected %h", got_v, exp_v); end
    sb.push_back(32'h0);
    read_reg(5'd8);
    got_v = writedata; exp_v = sb.pop_front(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL rereset_rf8: got %h expected %h", got_v, exp_v); end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_fetch_addi();
    test_branch();
    test_alu_ops();
    test_load_store();
    test_slt_jump();
    test_reg0_collision();
    test_reset_clears();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
